// File: rtl/pipeline_stage_buffer_pkg.sv
// Shared pipeline definitions: packed stage bundles, their widths and field
// offsets, plus a sizing helper for the stage buffer.
//   Bundles : if_id_t, id_ex_t, ex_mem_t, mem_wb_t
//   Widths  : IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W (use as buffer WIDTH)
//   Offsets : <BUNDLE>_<FIELD>_LSB, bit position of each field in the bundle
package pipeline_stage_buffer_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALUOP_W = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_val;
        logic [XLEN-1:0]    rs2_val;
        logic [XLEN-1:0]    imm;
        logic [REG_AW-1:0]  rd;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_rd;
        logic               mem_wr;
        logic               reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]   alu_res;
        logic [XLEN-1:0]   rs2_val;
        logic [REG_AW-1:0] rd;
        logic              mem_rd;
        logic              mem_wr;
        logic              reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]   wb_data;
        logic [REG_AW-1:0] rd;
        logic              reg_wr;
    } mem_wb_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

    // Field offsets: packed structs place the last member at bit 0.
    localparam int unsigned IF_ID_INSTR_LSB = 0;
    localparam int unsigned IF_ID_PC_LSB    = IF_ID_INSTR_LSB + XLEN;

    localparam int unsigned ID_EX_REG_WR_LSB  = 0;
    localparam int unsigned ID_EX_MEM_WR_LSB  = ID_EX_REG_WR_LSB + 1;
    localparam int unsigned ID_EX_MEM_RD_LSB  = ID_EX_MEM_WR_LSB + 1;
    localparam int unsigned ID_EX_ALU_OP_LSB  = ID_EX_MEM_RD_LSB + 1;
    localparam int unsigned ID_EX_RD_LSB      = ID_EX_ALU_OP_LSB + ALUOP_W;
    localparam int unsigned ID_EX_IMM_LSB     = ID_EX_RD_LSB + REG_AW;
    localparam int unsigned ID_EX_RS2_LSB     = ID_EX_IMM_LSB + XLEN;
    localparam int unsigned ID_EX_RS1_LSB     = ID_EX_RS2_LSB + XLEN;
    localparam int unsigned ID_EX_PC_LSB      = ID_EX_RS1_LSB + XLEN;

    localparam int unsigned EX_MEM_REG_WR_LSB  = 0;
    localparam int unsigned EX_MEM_MEM_WR_LSB  = EX_MEM_REG_WR_LSB + 1;
    localparam int unsigned EX_MEM_MEM_RD_LSB  = EX_MEM_MEM_WR_LSB + 1;
    localparam int unsigned EX_MEM_RD_LSB      = EX_MEM_MEM_RD_LSB + 1;
    localparam int unsigned EX_MEM_RS2_LSB     = EX_MEM_RD_LSB + REG_AW;
    localparam int unsigned EX_MEM_ALU_RES_LSB = EX_MEM_RS2_LSB + XLEN;

    localparam int unsigned MEM_WB_REG_WR_LSB = 0;
    localparam int unsigned MEM_WB_RD_LSB     = MEM_WB_REG_WR_LSB + 1;
    localparam int unsigned MEM_WB_DATA_LSB   = MEM_WB_RD_LSB + REG_AW;

    // Pointer width for a DEPTH-entry buffer; a single entry still needs one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipeline_ptr_counter.sv
// Wrapping pointer 0..DEPTH-1 for the stage buffer.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous return to 0 (has priority over inc)
//   inc      : advance by one, wrapping from DEPTH-1 to 0
//   ptr      : current pointer value (registered)
module pipeline_ptr_counter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PW    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] r_ptr;
    logic          w_last;

    // Explicit compare so non-power-of-2 depths wrap at DEPTH-1.
    assign w_last = (r_ptr == PW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= w_last ? '0 : r_ptr + PW'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/pipeline_stage_buffer.sv
// DEPTH-entry elastic buffer between two pipeline stages with valid/ready on
// both sides, freeze (stall) and flush (squash).
//   clk, rst            : clock, asynchronous active-low reset
//   freeze              : hold all state, block both handshakes
//   flush               : synchronous discard of all entries (highest priority)
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data head or FLUSH_VALUE
//   count               : occupancy 0..DEPTH
module pipeline_stage_buffer
    import pipeline_stage_buffer_pkg::*;
#(
    parameter  int unsigned      WIDTH       = 32,
    parameter  int unsigned      DEPTH       = 2,
    parameter  logic [WIDTH-1:0] FLUSH_VALUE = '0,
    localparam int unsigned      CW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_wptr;
    logic [PW-1:0]    w_rptr;
    logic             w_not_full;
    logic             w_not_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_adv_w;
    logic             w_adv_r;

    assign w_not_full  = (r_count < CW'(DEPTH));
    assign w_not_empty = (r_count != '0);

    // Handshakes depend only on local state, so no ready->ready path exists.
    assign in_ready  = !freeze && w_not_full;
    assign out_valid = !freeze && w_not_empty;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Flush squashes any transfer offered in the same cycle.
    assign w_adv_w = w_push && !flush;
    assign w_adv_r = w_pop && !flush;

    pipeline_ptr_counter #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_adv_w),
        .ptr (w_wptr)
    );

    pipeline_ptr_counter #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (w_adv_r),
        .ptr (w_rptr)
    );

    // Occupancy; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Storage is never cleared; the empty mask below hides stale entries.
    always_ff @(posedge clk) begin
        if (w_adv_w) begin
            r_mem[w_wptr] <= in_data;
        end
    end

    assign out_data = w_not_empty ? r_mem[w_rptr] : FLUSH_VALUE;
    assign count    = r_count;

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Bench for pipeline_stage_buffer: DUT A (DEPTH=2, WIDTH=32) and DUT B
// (DEPTH=3, WIDTH=8) share clock and reset. A scoreboard process records every
// accepted push and checks every pop in order; scenario tasks check status.
module tb_pipeline_stage_buffer;

    localparam logic [31:0] FV_A = 32'hDEAD_BEEF;
    localparam logic [7:0]  FV_B = 8'hEE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_freeze, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    logic        b_freeze, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [1:0]  b_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] qa[$];
    logic [7:0]  qb[$];

    pipeline_stage_buffer #(.WIDTH(32), .DEPTH(2), .FLUSH_VALUE(FV_A)) u_dut_a (
        .clk(clk), .rst(rst), .freeze(a_freeze), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count)
    );

    pipeline_stage_buffer #(.WIDTH(8), .DEPTH(3), .FLUSH_VALUE(FV_B)) u_dut_b (
        .clk(clk), .rst(rst), .freeze(b_freeze), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count)
    );

    // Scoreboard: samples mid low-phase, after the tasks have driven inputs.
    always begin
        logic [31:0] exp_a;
        logic [7:0]  exp_b;
        @(negedge clk);
        #2;
        if (!rst) begin
            qa.delete();
            qb.delete();
        end else begin
            assert (!(a_in_valid && a_in_ready && a_count == 2'd2)) else $error("push while full A");
            assert (!(a_out_valid && a_count == 2'd0)) else $error("pop while empty A");
            assert (!(b_in_valid && b_in_ready && b_count == 2'd3)) else $error("push while full B");
            assert (!(b_out_valid && b_count == 2'd0)) else $error("pop while empty B");
            if (a_flush) begin
                qa.delete();
            end else begin
                if (a_out_valid && a_out_ready) begin
                    checks++;
                    if (qa.size() == 0) begin
                        errors++;
                        $display("FAIL sb_a_unexpected_pop got %h expected nothing", a_out_data);
                    end else begin
                        exp_a = qa.pop_front();
                        if (a_out_data !== exp_a) begin
                            errors++;
                            $display("FAIL sb_a_data got %h expected %h", a_out_data, exp_a);
                        end
                    end
                end
                if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
            end
            if (b_flush) begin
                qb.delete();
            end else begin
                if (b_out_valid && b_out_ready) begin
                    checks++;
                    if (qb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_b_unexpected_pop got %h expected nothing", b_out_data);
                    end else begin
                        exp_b = qb.pop_front();
                        if (b_out_data !== exp_b) begin
                            errors++;
                            $display("FAIL sb_b_data got %h expected %h", b_out_data, exp_b);
                        end
                    end
                end
                if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
            end
        end
    end

    task automatic idle_all();
        a_freeze = 0; a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
        b_freeze = 0; b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_all();
        #12;
        checks++;
        if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== FV_A) begin
            errors++;
            $display("FAIL reset_a got cnt=%0d ov=%b ir=%b od=%h expected 0 0 1 %h",
                     a_count, a_out_valid, a_in_ready, a_out_data, FV_A);
        end
        checks++;
        if (b_count !== 2'd0 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_data !== FV_B) begin
            errors++;
            $display("FAIL reset_b got cnt=%0d ov=%b ir=%b od=%h expected 0 0 1 %h",
                     b_count, b_out_valid, b_in_ready, b_out_data, FV_B);
        end
        @(negedge clk) rst = 1'b1;
        @(negedge clk) begin a_in_valid = 1; a_in_data = 32'h10; end
        @(negedge clk) a_in_data = 32'h20;
        @(negedge clk) a_in_valid = 0;
        #1;
        checks++;
        if (a_count !== 2'd2) begin
            errors++;
            $display("FAIL reset_prefill got cnt=%0d expected 2", a_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== FV_A) begin
            errors++;
            $display("FAIL reset_async got cnt=%0d ov=%b ir=%b od=%h expected 0 0 1 %h",
                     a_count, a_out_valid, a_in_ready, a_out_data, FV_A);
        end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_fill_drain();
        @(negedge clk) begin a_in_valid = 1; a_in_data = 32'hA1; a_out_ready = 0; end
        @(negedge clk) a_in_data = 32'hB2;
        @(negedge clk) a_in_valid = 0;
        #1;
        checks++;
        if (a_count !== 2'd2 || a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== 32'hA1) begin
            errors++;
            $display("FAIL fill_full got cnt=%0d ir=%b ov=%b od=%h expected 2 0 1 000000a1",
                     a_count, a_in_ready, a_out_valid, a_out_data);
        end
        a_out_ready = 1;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_with_out_ready got %b expected 0", a_in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (a_count !== 2'd1 || a_out_data !== 32'hB2) begin
            errors++;
            $display("FAIL drain_mid got cnt=%0d od=%h expected 1 000000b2", a_count, a_out_data);
        end
        @(negedge clk);
        #1;
        a_out_ready = 0;
        checks++;
        if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== FV_A || qa.size() != 0) begin
            errors++;
            $display("FAIL drain_empty got cnt=%0d ov=%b od=%h q=%0d expected 0 0 %h 0",
                     a_count, a_out_valid, a_out_data, qa.size(), FV_A);
        end
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk) begin a_in_valid = 1; a_in_data = 32'(i); a_out_ready = 1; end
            #1;
            checks++;
            if (i == 1) begin
                if (a_out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_no_bypass got ov=%b expected 0", a_out_valid);
                end
            end else if (a_count !== 2'd1 || a_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_steady i=%0d got cnt=%0d ov=%b expected 1 1", i, a_count, a_out_valid);
            end
        end
        @(negedge clk) a_in_valid = 0;
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'd8) begin
            errors++;
            $display("FAIL stream_last got ov=%b od=%h expected 1 00000008", a_out_valid, a_out_data);
        end
        @(negedge clk) a_out_ready = 0;
        #1;
        checks++;
        if (a_count !== 2'd0 || qa.size() != 0) begin
            errors++;
            $display("FAIL stream_drained got cnt=%0d q=%0d expected 0 0", a_count, qa.size());
        end
    endtask

    task automatic test_freeze();
        @(negedge clk) begin a_in_valid = 1; a_in_data = 32'h11; a_out_ready = 0; end
        @(negedge clk) begin a_in_data = 32'h22; a_freeze = 1; a_out_ready = 1; end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_count !== 2'd1 || a_out_data !== 32'h11) begin
                errors++;
                $display("FAIL freeze_hold k=%0d got ir=%b ov=%b cnt=%0d od=%h expected 0 0 1 00000011",
                         k, a_in_ready, a_out_valid, a_count, a_out_data);
            end
        end
        @(negedge clk) begin a_freeze = 0; a_in_valid = 0; a_out_ready = 1; end
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'h11) begin
            errors++;
            $display("FAIL freeze_release got ov=%b od=%h expected 1 00000011", a_out_valid, a_out_data);
        end
        @(negedge clk) a_out_ready = 0;
        #1;
        checks++;
        if (a_count !== 2'd0) begin
            errors++;
            $display("FAIL freeze_drained got cnt=%0d expected 0", a_count);
        end
    endtask

    task automatic test_flush();
        @(negedge clk) begin a_in_valid = 1; a_in_data = 32'h33; a_out_ready = 0; end
        @(negedge clk) a_in_data = 32'h44;
        @(negedge clk) begin a_in_data = 32'h55; a_freeze = 1; a_flush = 1; end
        #1;
        checks++;
        if (a_count !== 2'd2) begin
            errors++;
            $display("FAIL flush_prefill got cnt=%0d expected 2", a_count);
        end
        @(negedge clk) begin a_in_valid = 0; a_freeze = 0; a_flush = 0; end
        #1;
        checks++;
        if (a_count !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== FV_A) begin
            errors++;
            $display("FAIL flush_clear got cnt=%0d ov=%b ir=%b od=%h expected 0 0 1 %h",
                     a_count, a_out_valid, a_in_ready, a_out_data, FV_A);
        end
        @(negedge clk) begin a_in_valid = 1; a_in_data = 32'h66; end
        @(negedge clk) begin a_in_valid = 0; a_out_ready = 1; end
        #1;
        checks++;
        if (a_out_data !== 32'h66) begin
            errors++;
            $display("FAIL flush_after got od=%h expected 00000066", a_out_data);
        end
        @(negedge clk) a_out_ready = 0;
        #1;
        checks++;
        if (a_count !== 2'd0 || qa.size() != 0) begin
            errors++;
            $display("FAIL flush_drained got cnt=%0d q=%0d expected 0 0", a_count, qa.size());
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            b_in_valid  = (sent < 10) && ((cyc % 5) != 4);
            b_in_data   = 8'(sent + 1);
            b_out_ready = ((cyc % 3) != 1);
            #1;
            checks++;
            if (int'(b_count) != qb.size() || b_count > 2'd3 ||
                b_in_ready !== (qb.size() < 3) || b_out_valid !== (qb.size() != 0)) begin
                errors++;
                $display("FAIL wrap_state cyc=%0d got cnt=%0d ir=%b ov=%b expected cnt=%0d",
                         cyc, b_count, b_in_ready, b_out_valid, qb.size());
            end
            if (b_in_valid && b_in_ready) sent++;
            if (sent == 10 && qb.size() == 0 && !b_in_valid) break;
        end
        b_in_valid = 0;
        b_out_ready = 0;
        checks++;
        if (sent != 10 || qb.size() != 0) begin
            errors++;
            $display("FAIL wrap_timeout got sent=%0d pending=%0d expected 10 0", sent, qb.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_freeze();
        test_flush();
        test_wrap();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
